// File: rtl/uart_midi_tx_pkg.sv
// uart_midi_tx_pkg: shared constants and FSM state type for the MIDI UART transmit path.
package uart_midi_tx_pkg;
   localparam int MIDI_BYTES = 24;
   localparam logic [7:0] STATUS_MIN = 8'h80;
   localparam logic [7:0] SYSCOM_MIN = 8'hF0;
   localparam logic [7:0] RT_MIN = 8'hF8;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_midi_tx_uart_tx.sv
// uart_tx: single-byte 8N1 serialiser, LSB first.
// ready_o is also high on the last stop-bit cycle so bytes can run back-to-back.
module uart_tx
   import uart_midi_tx_pkg::*;
#(
   parameter int CLOCKS_PER_BAUD = 32
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o
);
   localparam int CW = $clog2(CLOCKS_PER_BAUD);
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BAUD - 1);
   tx_state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] sh;
   logic last;
   assign last = cnt == LAST;
   assign ready_o = state == IDLE || (state == STOP && last);
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         sh <= '0;
         tx_o <= 1'b1;
      end else if (valid_i && ready_o) begin
         state <= START;
         cnt <= '0;
         sh <= data_i;
         tx_o <= 1'b0;
      end else if (state != IDLE) begin
         cnt <= last ? '0 : cnt + 1'b1;
         if (last)
            case (state)
               START: begin
                  state <= DATA;
                  tx_o <= sh[0];
                  sh <= sh >> 1;
                  bit_idx <= '0;
               end
               DATA:
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx_o <= 1'b1;
                  end else begin
                     tx_o <= sh[0];
                     sh <= sh >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: rtl/uart_midi_tx.sv
// uart_midi_tx: MIDI message sequencer with running-status compression over a uart_tx.
// The first byte is handed to the serialiser on the acceptance edge itself so the start bit follows at once.
module uart_midi_tx
   import uart_midi_tx_pkg::*;
#(
   parameter int CLOCKS_PER_BAUD = 32,
   parameter int RUNNING_STATUS = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  valid_in,
   input  logic [MIDI_BYTES-1:0] midi_bytes_in,
   input  logic [1:0]            len_in,
   output logic                  ready_out,
   output logic                  tx_out,
   output logic                  busy_out
);
   logic [7:0] b0, last_status, tx_data;
   logic chan, skip, tx_valid, tx_ready;
   logic [1:0] eff, rem;
   logic [MIDI_BYTES-1:0] msg;
   assign b0 = midi_bytes_in[23:16];
   assign chan = b0 >= STATUS_MIN && b0 < SYSCOM_MIN;
   assign skip = RUNNING_STATUS != 0 && len_in != 2'd0 && chan && b0 == last_status;
   assign eff = len_in - {1'b0, skip};
   assign tx_valid = busy_out ? rem != 2'd0 : ready_out && valid_in && eff != 2'd0;
   assign tx_data = busy_out ? msg[23:16] : skip ? midi_bytes_in[15:8] : b0;
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         ready_out <= 1'b0;
         busy_out <= 1'b0;
         msg <= '0;
         rem <= '0;
         last_status <= '0;
      end else if (ready_out) begin
         if (valid_in) begin
            ready_out <= 1'b0;
            busy_out <= 1'b1;
            msg <= skip ? midi_bytes_in << 16 : midi_bytes_in << 8;
            rem <= eff == 2'd0 ? 2'd0 : eff - 2'd1;
            if (RUNNING_STATUS != 0 && len_in != 2'd0)
               last_status <= chan ? b0 : (b0 >= SYSCOM_MIN && b0 < RT_MIN) ? 8'h00 : last_status;
         end
      end else if (busy_out) begin
         if (tx_ready && tx_valid) begin
            msg <= msg << 8;
            rem <= rem - 2'd1;
         end else if (tx_ready) begin
            ready_out <= 1'b1;
            busy_out <= 1'b0;
         end
      end else
         ready_out <= 1'b1;
   uart_tx #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_tx (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .data_i(tx_data),
      .valid_i(tx_valid),
      .ready_o(tx_ready),
      .tx_o(tx_out)
   );
endmodule

// File: tb/tb_uart_midi_tx.sv
// tb_uart_midi_tx: directed bit-exact checks of framing, timing and running status.
module tb_uart_midi_tx;
   logic clk = 1'b0, rst_n = 1'b0, v1 = 1'b0, v0 = 1'b0, sel = 1'b0;
   logic [23:0] bytes = '0;
   logic [1:0] len = '0;
   logic rdy1, tx1, busy1, rdy0, tx0, busy0, tx_s, rdy_s, busy_s;
   int checks = 0, failures = 0, cur = 0;
   logic [7:0] ls = 8'h00;
   always #5 clk = ~clk;
   uart_midi_tx #(.CLOCKS_PER_BAUD(32), .RUNNING_STATUS(1)) dut (
      .clk_in(clk), .rst_in(rst_n), .valid_in(v1), .midi_bytes_in(bytes), .len_in(len),
      .ready_out(rdy1), .tx_out(tx1), .busy_out(busy1));
   uart_midi_tx #(.CLOCKS_PER_BAUD(32), .RUNNING_STATUS(0)) dut0 (
      .clk_in(clk), .rst_in(rst_n), .valid_in(v0), .midi_bytes_in(bytes), .len_in(len),
      .ready_out(rdy0), .tx_out(tx0), .busy_out(busy0));
   assign tx_s = sel ? tx0 : tx1;
   assign rdy_s = sel ? rdy0 : rdy1;
   assign busy_s = sel ? busy0 : busy1;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
      checks++;
      assert (o === x) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
      end
   endtask

   task automatic goto(input int c);
      repeat (c - cur) @(negedge clk);
      cur = c;
   endtask

   // e holds the expected on-wire bytes from the top, n of them
   task automatic run_msg(input logic s, input logic [23:0] m, input logic [1:0] l,
                          input logic [23:0] e, input int n, input logic hold);
      logic [7:0] b;
      int fin;
      sel = s;
      @(negedge clk);
      cur = 0;
      chk("ready_before", {31'd0, rdy_s}, 1);
      bytes = m;
      len = l;
      if (s) v0 = 1'b1; else v1 = 1'b1;
      goto(1);
      bytes = ~m;
      len = ~l;
      if (!hold) begin v0 = 1'b0; v1 = 1'b0; end
      chk("busy_after_accept", {31'd0, busy_s}, 1);
      chk("ready_after_accept", {31'd0, rdy_s}, 0);
      if (n == 0) chk("tx_idle_len0", {31'd0, tx_s}, 1);
      for (int k = 0; k < n; k++) begin
         b = e[23-8*k -: 8];
         for (int j = 0; j < 10; j++) begin
            goto(k*320 + j*32 + 16);
            chk($sformatf("bit_b%0d_j%0d", k, j), {31'd0, tx_s},
                {31'd0, j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1]});
         end
      end
      fin = n == 0 ? 2 : n*320 + 1;
      goto(fin - 1);
      v0 = 1'b0;
      v1 = 1'b0;
      chk("ready_low_last", {31'd0, rdy_s}, 0);
      goto(fin);
      chk("ready_rise", {31'd0, rdy_s}, 1);
      chk("busy_fall", {31'd0, busy_s}, 0);
      chk("tx_idle_after", {31'd0, tx_s}, 1);
   endtask

   task automatic model(input logic [23:0] m, input logic [1:0] l, output logic [23:0] e, output int n);
      logic [7:0] b;
      logic sk;
      b = m[23:16];
      sk = l != 0 && b >= 8'h80 && b < 8'hF0 && b == ls;
      n = int'(l) - int'(sk);
      e = sk ? m << 8 : m;
      if (l != 0) ls = (b >= 8'h80 && b < 8'hF0) ? b : (b >= 8'hF0 && b < 8'hF8) ? 8'h00 : ls;
   endtask

   initial begin
      logic [23:0] m, e;
      logic [1:0] l;
      int n;
      @(negedge clk);
      chk("rst_tx", {31'd0, tx1}, 1);
      chk("rst_ready", {31'd0, rdy1}, 0);
      chk("rst_busy", {31'd0, busy1}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, rdy1}, 1);
      chk("ready0_after_rst", {31'd0, rdy0}, 1);
      run_msg(0, 24'h903C64, 2'd3, 24'h903C64, 3, 0);
      run_msg(0, 24'h904000, 2'd3, 24'h400000, 2, 0);
      run_msg(1, 24'h903C64, 2'd3, 24'h903C64, 3, 0);
      run_msg(1, 24'h904000, 2'd3, 24'h904000, 3, 0);
      run_msg(0, 24'hF80000, 2'd1, 24'hF80000, 1, 0);
      run_msg(0, 24'h903C64, 2'd3, 24'h3C6400, 2, 0);
      run_msg(0, 24'hF00000, 2'd1, 24'hF00000, 1, 0);
      run_msg(0, 24'h903C64, 2'd3, 24'h903C64, 3, 0);
      run_msg(0, 24'h904000, 2'd3, 24'h400000, 2, 1);
      run_msg(0, 24'h123456, 2'd0, 24'h000000, 0, 0);
      run_msg(0, 24'h3C6400, 2'd2, 24'h3C6400, 2, 0);
      run_msg(0, 24'h905000, 2'd2, 24'h500000, 1, 0);
      run_msg(0, 24'hA01020, 2'd3, 24'hA01020, 3, 0);
      run_msg(0, 24'hA00000, 2'd1, 24'h000000, 0, 0);
      // abort during data bit 4 of the second byte (0x00, so the line is low)
      sel = 0;
      @(negedge clk);
      cur = 0;
      bytes = 24'hB00064;
      len = 2'd3;
      v1 = 1'b1;
      goto(1);
      v1 = 1'b0;
      goto(320 + 5*32 + 10);
      chk("tx_before_abort", {31'd0, tx1}, 0);
      rst_n = 1'b0;
      #1;
      chk("tx_abort", {31'd0, tx1}, 1);
      chk("busy_abort", {31'd0, busy1}, 0);
      chk("ready_abort", {31'd0, rdy1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_abort", {31'd0, rdy1}, 1);
      chk("tx_after_abort", {31'd0, tx1}, 1);
      run_msg(0, 24'h903C64, 2'd3, 24'h903C64, 3, 0);
      ls = 8'h90;
      for (int i = 0; i < 50; i++) begin
         m = {$urandom_range(0, 1) != 0 ? 8'h90 : 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 127)), 8'($urandom_range(0, 127))};
         l = 2'($urandom_range(0, 3));
         model(m, l, e, n);
         run_msg(0, m, l, e, n, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_midi_tx.md
Name: uart_midi_tx

Overview:
- Transmit-side counterpart of the MIDI UART receive path.
- Accepts one MIDI message of up to 3 bytes, packed in the same layout the receiver produces, and serialises it on a UART line as 8N1, LSB first.
- Optional MIDI running-status compression: a repeated channel status byte is omitted.
- Feeds the external MIDI OUT / loopback pin; upstream is the synth control logic.

Parameters:
- CLOCKS_PER_BAUD, 32, clk_in cycles per UART bit period; matches the receive side.
- RUNNING_STATUS, 1, 1 = suppress a repeated channel status byte; 0 = always send all bytes.

Ports:
- clk_in  input  1  system clock, single clock domain.
- rst_in  input  1  asynchronous reset, active-low.
- valid_in  input  1  a message is presented on midi_bytes_in/len_in.
- midi_bytes_in  input  MIDI_BYTES  packed message: [23:16] first (status) byte, [15:8] second byte, [7:0] third byte.
- len_in  input  2  number of bytes to send, counted from the top of midi_bytes_in; valid values 0..3.
- ready_out  output  1  block can accept a message this cycle.
- tx_out  output  1  serial line; idles high.
- busy_out  output  1  a message is being serialised.

Behaviour:
- Reset, asynchronous while rst_in=0:
  - tx_out=1, ready_out=0, busy_out=0.
  - FSM goes to IDLE; last_status cleared to 0x00.
  - ready_out=1 from the first clk_in edge after rst_in deasserts.
  - Reset mid-frame aborts the byte: tx_out returns high immediately and no partial byte resumes.
- Handshake:
  - A message is accepted on a rising edge where valid_in && ready_out.
  - ready_out=1 only in IDLE.
  - midi_bytes_in and len_in are registered at acceptance; later changes are ignored.
- FSM states: IDLE -> START -> DATA -> STOP -> (NEXT byte: START | done: IDLE).
  - Every state except IDLE lasts exactly CLOCKS_PER_BAUD cycles per bit.
  - DATA lasts 8 bit periods, LSB first.
  - START drives 0; STOP drives 1.
- Timing:
  - tx_out drops to the start bit on the cycle after acceptance.
  - Bytes within a message are back-to-back: the next start bit follows the last stop-bit cycle directly.
  - ready_out rises on the cycle after the final stop-bit cycle, giving an N-byte message a throughput of N*10*CLOCKS_PER_BAUD cycles.
- busy_out=1 from the cycle after acceptance until ready_out rises.
- Byte count after acceptance: effective count = len_in, minus 1 if the status byte is suppressed.
  - Effective count 0: nothing is sent; tx_out stays 1; ready_out returns the cycle after acceptance.
- Running status (RUNNING_STATUS=1), evaluated on the first byte b0 only, and only when len_in>=1:
  - b0 in 0x80..0xEF and b0==last_status: b0 is skipped. Remaining bytes are sent.
  - b0 in 0x80..0xEF and b0!=last_status: b0 is sent; last_status<=b0.
  - b0 in 0xF0..0xF7 (system common / SysEx): b0 is sent; last_status<=0x00.
  - b0 in 0xF8..0xFF (real-time): b0 is sent; last_status unchanged.
  - b0 < 0x80 (data byte first): sent as-is; last_status unchanged.
- RUNNING_STATUS=0: last_status is never consulted; all len_in bytes are sent.
- Counter widths:
  - Baud counter is $clog2(CLOCKS_PER_BAUD) bits and wraps at CLOCKS_PER_BAUD-1.
  - Bit index is 3 bits; byte index is 2 bits.

Decomposition:
- Package constants:
  - MIDI_BYTES (=24) already lives in constants.
  - Add enum tx_state_t {IDLE, START, DATA, STOP}.
  - Add localparams STATUS_MIN=8'h80, SYSCOM_MIN=8'hF0 and RT_MIN=8'hF8.
- One natural sub-module: uart_tx, the single-byte 8N1 serialiser with data_i/valid_i/ready_o/tx_o and parameter CLOCKS_PER_BAUD, mirroring uart_rx.
- uart_midi_tx then holds only the message sequencer and running-status logic.

Test Plan:
1. Reset release, then 0x903C64 with len 3: 30 bit periods (960 cycles) on tx_out = 0x90, 0x3C, 0x64 LSB-first with start/stop bits; ready_out low throughout; ready_out rises on cycle 961.
2. Running status: 0x903C64 followed by 0x904000, both len 3 -> second message sends only 0x40, 0x00 (640 cycles). Repeat with RUNNING_STATUS=0 -> all 3 bytes sent.
3. 0xF80000 with len 1 between two 0x90 messages -> 0xF8 sent in 320 cycles; the following 0x90 is still suppressed. 0xF0 instead of 0xF8 -> the following 0x90 is re-sent.
4. Handshake edges:
   - valid_in held high while busy -> ignored; no data captured.
   - Input changed mid-transmission -> output unaffected.
   - len_in=0 -> tx_out stays 1; ready_out low for exactly 1 cycle.
5. rst_in pulsed low during bit 4 of byte 2 -> tx_out=1 within the same cycle, busy_out=0. Next 0x903C64 sends all 3 bytes because last_status was cleared.
6. Loopback: tx_out into uart_midi_rx, 50 random valid messages -> received midi_bytes matches the bytes sent, in order.
